// File: rtl/hbus_arb_pkg.sv
// hbus_arb_pkg: shared types and constants for the high-memory/IO bus arbiter.
// Rev 1.0
`default_nettype none

package hbus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_e;

   localparam logic [7:0]  TIMEOUT_RDATA = 8'hff;
   localparam logic [15:0] HIMEM_BASE    = 16'h0100;

endpackage

`default_nettype wire

// File: rtl/hbus_arb_if.sv
// hbus_arb_if: two requester ports plus the shared subordinate port of the bus.
// Rev 1.0
`default_nettype none

interface hbus_arb_if;

   logic [15:0] m0_addr;
   logic        m0_rreq;
   logic        m0_wreq;
   logic [7:0]  m0_wdata;
   logic [7:0]  m0_rdata;
   logic        m0_ack;

   logic [15:0] m1_addr;
   logic        m1_rreq;
   logic        m1_wreq;
   logic [7:0]  m1_wdata;
   logic [7:0]  m1_rdata;
   logic        m1_ack;

   logic [15:0] s_addr;
   logic        s_rreq;
   logic        s_wreq;
   logic [7:0]  s_wdata;
   logic [7:0]  s_rdata;
   logic        s_ack;

   // Arbiter side: subordinate to both mains, main towards the fabric.
   modport slave (
      input  m0_addr, m0_rreq, m0_wreq, m0_wdata,
      output m0_rdata, m0_ack,
      input  m1_addr, m1_rreq, m1_wreq, m1_wdata,
      output m1_rdata, m1_ack,
      output s_addr, s_rreq, s_wreq, s_wdata,
      input  s_rdata, s_ack
   );

   modport master (
      output m0_addr, m0_rreq, m0_wreq, m0_wdata,
      input  m0_rdata, m0_ack,
      output m1_addr, m1_rreq, m1_wreq, m1_wdata,
      input  m1_rdata, m1_ack,
      input  s_addr, s_rreq, s_wreq, s_wdata,
      output s_rdata, s_ack
   );

endinterface

`default_nettype wire

// File: rtl/hbus_arb_rr2.sv
// arb_rr2: two-input round-robin picker; on a tie the main that was not served last wins.
// Rev 1.0
`default_nettype none

module arb_rr2 (
   input  wire logic       req0_i,
   input  wire logic       req1_i,
   input  wire logic       last_i,
   output logic [1:0]      gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req0_i && req1_i) begin
         gnt_o = last_i ? 2'b01 : 2'b10;
      end else if (req0_i) begin
         gnt_o = 2'b01;
      end else if (req1_i) begin
         gnt_o = 2'b10;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hbus_arb.sv
// hbus_arb: shares the subordinate bus between core (m0) and a second main (m1), with ack timeout.
// Rev 1.0
`default_nettype none

module hbus_arb
   import hbus_arb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  wire logic   clk,
   input  wire logic   rst,
   hbus_arb_if.slave   bus,
   input  wire logic   err_clr,
   output logic        err,
   output logic [15:0] err_addr
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   arb_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        err_q, err_d;
   logic [15:0] err_addr_q, err_addr_d;

   logic        req0, req1;
   logic [1:0]  gnt;
   logic        active;
   logic        sel1;
   logic [15:0] g_addr;
   logic        g_rreq, g_wreq;
   logic [7:0]  g_wdata;
   logic        ack;
   logic [7:0]  rdata;
   logic        err_set;

   assign req0 = bus.m0_rreq | bus.m0_wreq;
   assign req1 = bus.m1_rreq | bus.m1_wreq;

   arb_rr2 u_rr2 (
      .req0_i (req0),
      .req1_i (req1),
      .last_i (last_q),
      .gnt_o  (gnt)
   );

   assign sel1    = (state_q == ARB_GNT1);
   assign active  = ~rst & ((state_q == ARB_GNT0) | (state_q == ARB_GNT1));
   assign g_addr  = sel1 ? bus.m1_addr  : bus.m0_addr;
   assign g_rreq  = sel1 ? bus.m1_rreq  : bus.m0_rreq;
   assign g_wreq  = sel1 ? bus.m1_wreq  : bus.m0_wreq;
   assign g_wdata = sel1 ? bus.m1_wdata : bus.m0_wdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      last_d     = last_q;
      err_addr_d = err_addr_q;
      err_set    = 1'b0;
      ack        = 1'b0;
      rdata      = '0;
      case (state_q)
         ARB_IDLE: begin
            if (gnt[0]) begin
               state_d = ARB_GNT0;
            end else if (gnt[1]) begin
               state_d = ARB_GNT1;
            end
         end
         ARB_GNT0, ARB_GNT1: begin
            rdata = bus.s_rdata;
            if (!(g_rreq | g_wreq)) begin
               // Main gave up before any ack: silent return, fairness untouched.
               state_d = ARB_IDLE;
            end else if (bus.s_ack) begin
               ack     = 1'b1;
               state_d = ARB_IDLE;
               last_d  = sel1;
            end else if (cnt_q == CNT_LAST) begin
               ack        = 1'b1;
               rdata      = TIMEOUT_RDATA;
               state_d    = ARB_IDLE;
               last_d     = sel1;
               err_set    = 1'b1;
               err_addr_d = g_addr;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.s_addr   = active ? g_addr  : '0;
   assign bus.s_rreq   = active & g_rreq;
   assign bus.s_wreq   = active & g_wreq;
   assign bus.s_wdata  = active ? g_wdata : '0;

   assign bus.m0_ack   = active & ~sel1 & ack;
   assign bus.m1_ack   = active &  sel1 & ack;
   assign bus.m0_rdata = (active & ~sel1) ? rdata : '0;
   assign bus.m1_rdata = (active &  sel1) ? rdata : '0;

   assign err      = ~rst & err_q;
   assign err_addr = rst ? '0 : err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_hbus_arb.sv
// tb_hbus_arb: randomized transaction-level model of the arbiter with an ack scoreboard.
// Rev 1.0
`default_nettype none

module tb_hbus_arb;
   import hbus_arb_pkg::*;

   localparam int TO = 16;

   typedef struct {
      int         k;
      logic [7:0] rd;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        err_clr;
   logic        err;
   logic [15:0] err_addr;

   hbus_arb_if bus ();

   hbus_arb #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .err_clr  (err_clr),
      .err      (err),
      .err_addr (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   exp_t        mon_e;

   logic [1:0]  pend;
   logic [15:0] tx_addr [2];
   logic        tx_wr   [2];
   logic [7:0]  tx_wd   [2];
   logic        last_m;
   logic        err_m;
   logic [15:0] erra_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every ack must match the oldest predicted completion.
   always @(negedge clk) begin
      if (!rst && (bus.m0_ack || bus.m1_ack)) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("both_acks", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
            chk("ack_main", {31'd0, bus.m1_ack}, mon_e.k);
            chk("ack_rdata", (mon_e.k == 1) ? bus.m1_rdata : bus.m0_rdata, mon_e.rd);
            chk("other_rdata", (mon_e.k == 1) ? bus.m0_rdata : bus.m1_rdata, 32'd0);
         end
      end
   end

   task automatic drive_mains();
      bus.m0_addr  = tx_addr[0];
      bus.m0_rreq  = pend[0] & ~tx_wr[0];
      bus.m0_wreq  = pend[0] &  tx_wr[0];
      bus.m0_wdata = tx_wd[0];
      bus.m1_addr  = tx_addr[1];
      bus.m1_rreq  = pend[1] & ~tx_wr[1];
      bus.m1_wreq  = pend[1] &  tx_wr[1];
      bus.m1_wdata = tx_wd[1];
   endtask

   task automatic set_tx(input int k, input logic [15:0] a, input logic w, input logic [7:0] wd);
      tx_addr[k] = a;
      tx_wr[k]   = w;
      tx_wd[k]   = wd;
      pend[k]    = 1'b1;
   endtask

   task automatic new_tx(input int k);
      set_tx(k, HIMEM_BASE + 16'($urandom_range(0, 32'hfeff)), 1'($urandom), 8'($urandom));
   endtask

   task automatic idle_checks();
      chk("idle_fwd", {6'd0, bus.s_addr, bus.s_rreq, bus.s_wreq, bus.s_wdata}, 32'd0);
      chk("err", {31'd0, err}, {31'd0, err_m});
      chk("err_addr", {16'd0, err_addr}, {16'd0, erra_m});
      chk("ack_pending", q.size(), 32'd0);
   endtask

   task automatic idle_cycle();
      logic clr;
      drive_mains();
      bus.s_ack   = 1'b0;
      bus.s_rdata = 8'($urandom);
      clr         = ($urandom % 4 == 0);
      err_clr     = clr;
      @(negedge clk);
      idle_checks();
      @(posedge clk); #1;
      if (clr) err_m = 1'b0;
   endtask

   // One full transaction: the ack arrives dly cycles into the grant, or never if dly >= TO.
   task automatic run_tx(input int dly, input logic [7:0] rd);
      int   w;
      logic tmo;
      logic clr;
      drive_mains();
      bus.s_ack   = 1'b0;
      bus.s_rdata = 8'($urandom);
      clr         = ($urandom % 4 == 0);
      err_clr     = clr;
      @(negedge clk);
      idle_checks();
      w   = (pend == 2'b11) ? (last_m ? 0 : 1) : (pend[0] ? 0 : 1);
      tmo = (dly >= TO);
      q.push_back('{w, tmo ? TIMEOUT_RDATA : rd});
      @(posedge clk); #1;
      if (clr) err_m = 1'b0;
      for (int c = 0; c < TO; c++) begin
         bus.s_ack   = (c == dly);
         bus.s_rdata = (c == dly) ? rd : 8'($urandom);
         clr         = ($urandom % 4 == 0);
         err_clr     = clr;
         @(negedge clk);
         chk("fwd", {6'd0, bus.s_addr, bus.s_rreq, bus.s_wreq, bus.s_wdata},
             {6'd0, tx_addr[w], ~tx_wr[w], tx_wr[w], tx_wd[w]});
         @(posedge clk); #1;
         if (c == dly || c == TO - 1) begin
            if (c != dly) begin
               err_m  = 1'b1;
               erra_m = tx_addr[w];
            end else if (clr) begin
               err_m = 1'b0;
            end
            last_m  = (w == 1);
            pend[w] = 1'b0;
            drive_mains();
            bus.s_ack = 1'b0;
            err_clr   = 1'b0;
            break;
         end
         if (clr) err_m = 1'b0;
      end
   endtask

   function automatic int rand_dly();
      case ($urandom % 6)
         0:       return 0;
         1:       return 1;
         2:       return $urandom_range(2, 5);
         3:       return TO - 1;
         4:       return TO + 5;
         default: return $urandom_range(0, TO - 1);
      endcase
   endfunction

   initial begin
      rst         = 1'b1;
      err_clr     = 1'b0;
      pend        = 2'b00;
      for (int k = 0; k < 2; k++) begin
         tx_addr[k] = '0;
         tx_wr[k]   = 1'b0;
         tx_wd[k]   = '0;
      end
      drive_mains();
      bus.s_ack   = 1'b0;
      bus.s_rdata = '0;
      err_m       = 1'b0;
      erra_m      = '0;
      last_m      = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      idle_checks();
      chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Tie from reset exit with a zero-wait subordinate: m0, m1, m0, m1.
      new_tx(0);
      new_tx(1);
      for (int i = 0; i < 4; i++) begin
         run_tx(0, 8'($urandom));
         new_tx(last_m ? 1 : 0);
      end
      pend = 2'b00;
      drive_mains();

      set_tx(0, 16'h1234, 1'b0, 8'h00);
      run_tx(3, 8'h5a);
      set_tx(1, 16'h0400, 1'b1, 8'hc3);
      run_tx(TO + 5, 8'h00);
      set_tx(0, 16'h0abc, 1'b0, 8'h00);
      run_tx(TO - 1, 8'h33);

      for (int n = 0; n < 80; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && ($urandom % 2 == 1)) new_tx(k);
         end
         if (pend == 2'b00) idle_cycle();
         else               run_tx(rand_dly(), 8'($urandom));
      end
      pend = 2'b00;
      idle_cycle();

      // Reset in the middle of a granted m0 read.
      set_tx(0, 16'h2468, 1'b0, 8'h00);
      drive_mains();
      err_clr = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_fwd", {31'd0, bus.s_rreq}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst    = 1'b0;
      err_m  = 1'b0;
      erra_m = '0;
      last_m = 1'b1;
      @(negedge clk);
      chk("post_rst_fwd", {6'd0, bus.s_addr, bus.s_rreq, bus.s_wreq, bus.s_wdata}, 32'd0);
      chk("post_rst_err", {15'd0, err, err_addr}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("regrant", {15'd0, bus.s_addr, bus.s_rreq}, {15'd0, 16'h2468, 1'b1});
      @(posedge clk); #1;
      q.push_back('{0, 8'h77});
      bus.s_ack   = 1'b1;
      bus.s_rdata = 8'h77;
      @(posedge clk); #1;
      bus.s_ack = 1'b0;
      pend      = 2'b00;
      last_m    = 1'b0;
      drive_mains();

      // Abandon by m1 with a stray s_ack in the drop cycle: no ack, fairness unchanged.
      set_tx(1, 16'h0800, 1'b1, 8'h11);
      drive_mains();
      @(negedge clk);
      idle_checks();
      @(posedge clk); #1;
      @(negedge clk);
      chk("abandon_fwd", {31'd0, bus.s_wreq}, 32'd1);
      @(posedge clk); #1;
      pend = 2'b00;
      drive_mains();
      bus.s_ack = 1'b1;
      @(negedge clk);
      chk("abandon_req", {30'd0, bus.s_rreq, bus.s_wreq}, 32'd0);
      @(posedge clk); #1;
      bus.s_ack = 1'b0;
      new_tx(0);
      new_tx(1);
      run_tx(1, 8'($urandom));
      run_tx(0, 8'($urandom));
      idle_cycle();

      @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
